lcd_stream_reader: RTL and testbench
====================================

# lcd_stream_reader

LCD-side consumer of the tokenised 17-bit frame stream that the VideoController pushes into the dual-clock output FIFO. It pops tokens on the LCD clock and checks the frame/row syntax against the configured geometry. Pixels go out on a valid/ready interface with start-of-frame, end-of-line and end-of-frame markers. Syntax violations are flagged and counted, and the block resynchronises on the next frame start.

## Interface
Parameters:
- FRAME_WIDTH, 480 — pixels per row expected between row markers.
- FRAME_HEIGHT, 272 — rows per frame.
- TOK_FRAME_START, 17'h10000 — frame start token.
- TOK_ROW_START, 17'h10001 — row start token.
- TOK_FRAME_END, 17'h1FFFF — frame end token.

Ports:
- clk  in  1  LCD pixel clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- queue_data  in  17  FIFO Q; valid the cycle after a pop.
- queue_empty  in  1  FIFO empty flag.
- queue_rd_en  out  1  FIFO pop request.
- pix_data  out  16  RGB565 pixel.
- pix_valid  out  1  pixel present.
- pix_ready  in  1  downstream accepts when high with pix_valid.
- pix_sof  out  1  qualifies the first pixel of a frame.
- pix_eol  out  1  qualifies the last pixel of a row.
- pix_eof  out  1  qualifies the last pixel of a frame.
- frame_done  out  1  one-cycle pulse when FRAME_END is accepted in the correct position.
- proto_error  out  1  one-cycle pulse on any syntax violation.
- error_count  out  8  saturating violation count.

## Operation
Token classes:
- bit16 = 0: pixel, payload [15:0].
- bit16 = 1: must equal one of the three markers. Any other value is a violation.

Parser FSM (evaluated on each token arriving from the FIFO):
- WAIT_FRAME (reset state): FRAME_START → WAIT_ROW with row = 0. All other tokens are discarded silently, with no error.
- WAIT_ROW: ROW_START → PIXELS with col = 0. Any other token is a violation.
- PIXELS: a pixel is written to the skid buffer with markers:
  - sof = (row == 0 && col == 0)
  - eol = (col == FRAME_WIDTH-1)
  - eof = eol && (row == FRAME_HEIGHT-1)
  - After the last pixel of a row: row++, then → WAIT_END if row == FRAME_HEIGHT, else → WAIT_ROW.
  - Any marker token in PIXELS is a violation.
- WAIT_END: FRAME_END → WAIT_FRAME with a frame_done pulse. Any other token is a violation.

Violation handling:
- proto_error pulses and error_count increments, saturating at 255.
- The FSM goes to WAIT_FRAME.
- Exception: if the offending token is FRAME_START, the violation is still counted, but the FSM goes directly to WAIT_ROW with row = 0 (immediate resync).

Counters:
- col is clog2(FRAME_WIDTH) bits; row is clog2(FRAME_HEIGHT+1) bits.
- Both are cleared on FRAME_START and ROW_START respectively.

Output path:
- 2-entry skid FIFO of {eof, eol, sof, data}. The head entry drives the pix_* outputs.
- Pixels already emitted before a violation are not retracted.

Pop control:
- queue_rd_en = !queue_empty && (skid_count + inflight < 2).
- inflight = queue_rd_en registered, i.e. a token is arriving this cycle.
- Marker tokens occupy no skid slot but still count as in flight.

## Timing
Reset values: queue_rd_en, pix_valid, pix_sof, pix_eol, pix_eof, frame_done, proto_error = 0; pix_data = 0; error_count = 0; FSM = WAIT_FRAME; skid empty; inflight = 0.

Latency and throughput:
- Pop at cycle n → token on queue_data at n+1 → pix_valid at n+2.
- Sustained rate is 1 pixel/cycle while pix_ready = 1 and the FIFO is non-empty.

Handshake:
- pix_data and markers stay stable while pix_valid && !pix_ready.
- A transfer happens on pix_valid && pix_ready.
- A push and a pop of the skid in the same cycle keep the count unchanged.

Flags:
- frame_done and proto_error are registered, asserted the cycle after the deciding token arrives.
- error_count updates in the same cycle as proto_error.

Boundaries:
- queue_empty alone never blocks a token already in flight. It is always consumed the next cycle.
- The skid never overflows: pop control guarantees arrival only into a free slot.
- Reset mid-frame: everything clears asynchronously. Tokens after reset are discarded until FRAME_START.

## Test plan
- Clean frame (W=4, H=3, pix_ready=1): FRAME_START, 3×(ROW_START + 4 pixels), FRAME_END → 12 pixels in order; sof on pixel 1; eol on pixels 4, 8, 12; eof on pixel 12 only; one frame_done; error_count = 0; first pix_valid 2 cycles after the first pixel pop.
- Back-pressure: the same frame with pix_ready toggling pseudo-randomly (about 50%) → identical pixel sequence, no drop or duplicate; queue_rd_en never high when skid_count + inflight = 2; outputs stable while stalled.
- Leading garbage: 0x1234, ROW_START, FRAME_END, then a clean frame → the garbage yields no pix_valid and no proto_error; the clean frame is output correctly.
- Short row: ROW_START + 3 pixels then ROW_START → one proto_error, error_count = 1, FSM back in WAIT_FRAME; the next clean frame outputs 12 pixels and frame_done.
- Mid-frame FRAME_START and missing FRAME_END:
  - FRAME_START after 5 pixels → error_count increments; the following tokens are parsed as a new frame, whose first pixel carries sof.
  - ROW_START in WAIT_END → violation.
  - Unknown marker 17'h10005 in PIXELS → violation.
  - After 256 violations, error_count holds at 255.
- Reset: rst_n low for 1 cycle at an arbitrary mid-frame point → all outputs 0 immediately; the rest of the interrupted frame is discarded silently; the next frame is output correctly.

Source files
------------

// File: rtl/lcd_stream_reader.sv
// rtl/lcd_stream_reader.sv - LCD-side frame token parser with a 2-entry pixel skid buffer
module lcd_stream_reader #(
    parameter int          FRAME_WIDTH     = 480,
    parameter int          FRAME_HEIGHT    = 272,
    parameter logic [16:0] TOK_FRAME_START = 17'h10000,
    parameter logic [16:0] TOK_ROW_START   = 17'h10001,
    parameter logic [16:0] TOK_FRAME_END   = 17'h1FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [16:0] queue_data,
    input  logic        queue_empty,
    output logic        queue_rd_en,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        pix_eof,
    output logic        frame_done,
    output logic        proto_error,
    output logic [7:0]  error_count
);
    localparam int COL_W = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
    localparam int ROW_W = $clog2(FRAME_HEIGHT + 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(FRAME_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FRAME_HEIGHT - 1);

    typedef enum logic [1:0] {
        WAIT_FRAME,
        WAIT_ROW,
        PIXELS,
        WAIT_END
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [COL_W-1:0] col;
    logic [COL_W-1:0] col_nxt;
    logic [ROW_W-1:0] row;
    logic [ROW_W-1:0] row_nxt;
    logic             inflight;
    logic             viol;
    logic             done;
    logic             push;
    logic             pop;
    logic [2:0]       push_marks;

    logic [18:0]      skid_mem [2];
    logic             skid_wr_ptr;
    logic             skid_rd_ptr;
    logic [1:0]       skid_count;
    logic [18:0]      skid_head;

    logic             is_pixel;
    logic             is_fs;
    logic             is_rs;
    logic             is_fe;

    assign is_pixel = !queue_data[16];
    assign is_fs    = (queue_data == TOK_FRAME_START);
    assign is_rs    = (queue_data == TOK_ROW_START);
    assign is_fe    = (queue_data == TOK_FRAME_END);

    // Only pop when the token that would arrive is guaranteed a free skid slot;
    // markers are counted too since their class is unknown until they arrive.
    assign queue_rd_en = rst_n && !queue_empty &&
                         (({1'b0, skid_count} + {2'b00, inflight}) < 3'd2);

    assign skid_head   = skid_mem[skid_rd_ptr];
    assign pix_valid   = (skid_count != 2'd0);
    assign pix_data    = pix_valid ? skid_head[15:0] : 16'h0000;
    assign pix_sof     = pix_valid && skid_head[16];
    assign pix_eol     = pix_valid && skid_head[17];
    assign pix_eof     = pix_valid && skid_head[18];
    assign pop         = pix_valid && pix_ready;

    // Parser: decide next state, counters, skid push and flags for the arriving token.
    always_comb begin
        state_nxt  = state;
        col_nxt    = col;
        row_nxt    = row;
        viol       = 1'b0;
        done       = 1'b0;
        push       = 1'b0;
        push_marks = 3'b000;
        if (inflight) begin
            unique case (state)
                WAIT_FRAME: begin
                    if (is_fs) begin
                        state_nxt = WAIT_ROW;
                        row_nxt   = '0;
                    end
                end
                WAIT_ROW: begin
                    if (is_rs) begin
                        state_nxt = PIXELS;
                        col_nxt   = '0;
                    end else begin
                        viol = 1'b1;
                    end
                end
                PIXELS: begin
                    if (is_pixel) begin
                        push       = 1'b1;
                        push_marks = {(col == COL_LAST) && (row == ROW_LAST),
                                      (col == COL_LAST),
                                      (row == '0) && (col == '0)};
                        if (col == COL_LAST) begin
                            row_nxt   = row + 1'b1;
                            state_nxt = (row == ROW_LAST) ? WAIT_END : WAIT_ROW;
                        end else begin
                            col_nxt = col + 1'b1;
                        end
                    end else begin
                        viol = 1'b1;
                    end
                end
                WAIT_END: begin
                    if (is_fe) begin
                        done      = 1'b1;
                        state_nxt = WAIT_FRAME;
                    end else begin
                        viol = 1'b1;
                    end
                end
                default: state_nxt = WAIT_FRAME;
            endcase
            // A stray frame start still counts as an error but begins a new frame at once.
            if (viol) begin
                state_nxt = is_fs ? WAIT_ROW : WAIT_FRAME;
                if (is_fs) begin
                    row_nxt = '0;
                end
            end
        end
    end

    // Parser state, counters, in-flight tracking and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= WAIT_FRAME;
            col         <= '0;
            row         <= '0;
            inflight    <= 1'b0;
            frame_done  <= 1'b0;
            proto_error <= 1'b0;
            error_count <= 8'd0;
        end else begin
            state       <= state_nxt;
            col         <= col_nxt;
            row         <= row_nxt;
            inflight    <= queue_rd_en;
            frame_done  <= done;
            proto_error <= viol;
            if (viol && (error_count != 8'hFF)) begin
                error_count <= error_count + 8'd1;
            end
        end
    end

    // Skid buffer: entries are {eof, eol, sof, data}; head drives the pixel outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_mem[0] <= '0;
            skid_mem[1] <= '0;
            skid_wr_ptr <= 1'b0;
            skid_rd_ptr <= 1'b0;
            skid_count  <= 2'd0;
        end else begin
            if (push) begin
                skid_mem[skid_wr_ptr] <= {push_marks, queue_data[15:0]};
                skid_wr_ptr           <= ~skid_wr_ptr;
            end
            if (pop) begin
                skid_rd_ptr <= ~skid_rd_ptr;
            end
            case ({push, pop})
                2'b10:   skid_count <= skid_count + 2'd1;
                2'b01:   skid_count <= skid_count - 2'd1;
                default: skid_count <= skid_count;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_stream_reader.sv
// tb/tb_lcd_stream_reader.sv - self-checking bench for lcd_stream_reader
module tb_lcd_stream_reader;
    localparam int W = 4;
    localparam int H = 3;
    localparam int FRAME_LEN = 2 + H * (W + 1);
    localparam logic [16:0] FS = 17'h10000;
    localparam logic [16:0] RS = 17'h10001;
    localparam logic [16:0] FE = 17'h1FFFF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [16:0] queue_data;
    logic        queue_empty;
    logic        queue_rd_en;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_sof;
    logic        pix_eol;
    logic        pix_eof;
    logic        frame_done;
    logic        proto_error;
    logic [7:0]  error_count;

    always #5 clk = ~clk;

    lcd_stream_reader #(
        .FRAME_WIDTH (W),
        .FRAME_HEIGHT(H)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .queue_data (queue_data),
        .queue_empty(queue_empty),
        .queue_rd_en(queue_rd_en),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_sof    (pix_sof),
        .pix_eol    (pix_eol),
        .pix_eof    (pix_eof),
        .frame_done (frame_done),
        .proto_error(proto_error),
        .error_count(error_count)
    );

    int          checks = 0;
    int          failures = 0;
    logic [16:0] tq[$];
    logic [18:0] exp_q[$];
    int          m_pos = -1;
    int          m_cnt = 0;
    int          exp_cnt = 0;
    logic        nxt_done = 1'b0;
    logic        nxt_err = 1'b0;
    logic        exp_done = 1'b0;
    logic        exp_err = 1'b0;
    logic        cur_push = 1'b0;
    logic        cur_infl = 1'b0;
    int          ready_mode = 2;
    int          done_seen = 0;
    int          err_seen = 0;
    int          pix_seen = 0;
    int          sof_seen = 0;
    int          eol_seen = 0;
    int          eof_seen = 0;
    logic [15:0] first_pix = 16'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Frame grammar as a flat position: 0 FS, then H groups of (RS + W pixels), then FE.
    task automatic model_step(input logic [16:0] t);
        int   k;
        int   r;
        int   c;
        logic ok;
        cur_push = 1'b0;
        if (m_pos < 0) begin
            if (t == FS) m_pos = 1;
            return;
        end
        k = (m_pos - 1) % (W + 1);
        if (m_pos == FRAME_LEN - 1) ok = (t == FE);
        else if (k == 0)            ok = (t == RS);
        else                        ok = !t[16];
        if (ok) begin
            if (m_pos != FRAME_LEN - 1 && k != 0) begin
                r = (m_pos - 1) / (W + 1);
                c = k - 1;
                exp_q.push_back({(c == W - 1 && r == H - 1), (c == W - 1), (r == 0 && c == 0), t[15:0]});
                cur_push = 1'b1;
            end
            if (m_pos == FRAME_LEN - 1) begin
                nxt_done = 1'b1;
                m_pos = -1;
            end else begin
                m_pos++;
            end
        end else begin
            nxt_err = 1'b1;
            if (m_cnt < 255) m_cnt++;
            m_pos = (t == FS) ? 1 : -1;
        end
    endtask

    task automatic add_frame(input logic [15:0] base);
        tq.push_back(FS);
        for (int r = 0; r < H; r++) begin
            tq.push_back(RS);
            for (int c = 0; c < W; c++) tq.push_back({1'b0, base + 16'(r * W + c)});
        end
        tq.push_back(FE);
    endtask

    task automatic clear_seen();
        done_seen = 0; err_seen = 0; pix_seen = 0;
        sof_seen = 0; eol_seen = 0; eof_seen = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((tq.size() != 0 || exp_q.size() != 0 || queue_rd_en) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        repeat (4) @(posedge clk);
        checks++;
        if (n >= 2000) begin
            failures++;
            $display("FAIL drain_timeout: tokens left %0d pixels left %0d", tq.size(), exp_q.size());
        end
    endtask

    // FIFO model: a pop seen before the edge delivers the next token just after it.
    initial begin : driver
        logic        rd_pend;
        logic [16:0] tok;
        forever begin
            @(negedge clk);
            rd_pend = queue_rd_en;
            @(posedge clk);
            #1;
            exp_done = nxt_done;
            exp_err  = nxt_err;
            exp_cnt  = m_cnt;
            nxt_done = 1'b0;
            nxt_err  = 1'b0;
            cur_push = 1'b0;
            cur_infl = 1'b0;
            if (rd_pend && tq.size() > 0) begin
                tok = tq.pop_front();
                queue_data = tok;
                cur_infl = 1'b1;
                model_step(tok);
            end else begin
                queue_data = 17'($urandom);
            end
            queue_empty = (tq.size() == 0);
            pix_ready = (ready_mode == 0) ? 1'b1 :
                        (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // Per-cycle comparison against the model, sampled on the falling edge.
    initial begin : compare
        logic        prev_stall;
        logic [18:0] prev_out;
        logic [18:0] got;
        logic [18:0] e;
        int          occ;
        prev_stall = 1'b0;
        prev_out   = '0;
        forever begin
            @(negedge clk);
            occ = exp_q.size() - int'(cur_push);
            got = {pix_eof, pix_eol, pix_sof, pix_data};
            check("pix_valid", 32'(pix_valid), 32'(occ != 0));
            if (queue_rd_en) check("rd_en_room", 32'((occ + int'(cur_infl)) < 2), 32'd1);
            check("frame_done", 32'(frame_done), 32'(exp_done));
            check("proto_error", 32'(proto_error), 32'(exp_err));
            check("error_count", 32'(error_count), 32'(exp_cnt));
            if (prev_stall && rst_n) check("stall_hold", 32'({pix_valid, got}), 32'({1'b1, prev_out}));
            if (pix_valid && pix_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_pixel: got %0h expected none", got);
                end else begin
                    e = exp_q.pop_front();
                    check("pixel", 32'(got), 32'(e));
                    if (pix_seen == 0) first_pix = pix_data;
                    pix_seen++;
                    if (pix_sof) sof_seen++;
                    if (pix_eol) eol_seen++;
                    if (pix_eof) eof_seen++;
                end
            end
            if (frame_done) done_seen++;
            if (proto_error) err_seen++;
            prev_stall = pix_valid && !pix_ready;
            prev_out   = got;
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $finish;
    end

    initial begin : main
        rst_n = 1'b0; pix_ready = 1'b0; queue_empty = 1'b1; queue_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(pix_valid), 32'd0);
        check("rst_rd_en", 32'(queue_rd_en), 32'd0);
        check("rst_data", 32'(pix_data), 32'd0);
        check("rst_count", 32'(error_count), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Clean frame, always ready
        ready_mode = 0; clear_seen();
        add_frame(16'hA000);
        drain();
        check("s1_frames", 32'(done_seen), 32'd1);
        check("s1_pixels", 32'(pix_seen), 32'd12);
        check("s1_sof", 32'(sof_seen), 32'd1);
        check("s1_eol", 32'(eol_seen), 32'd3);
        check("s1_eof", 32'(eof_seen), 32'd1);
        check("s1_first", 32'(first_pix), 32'hA000);
        check("s1_errcnt", 32'(error_count), 32'd0);

        // Same frame with random back-pressure
        ready_mode = 1; clear_seen();
        add_frame(16'hB000);
        drain();
        check("s2_frames", 32'(done_seen), 32'd1);
        check("s2_pixels", 32'(pix_seen), 32'd12);
        check("s2_errs", 32'(err_seen), 32'd0);

        // Leading garbage is discarded silently
        ready_mode = 0; clear_seen();
        tq.push_back(17'h01234); tq.push_back(RS); tq.push_back(FE);
        add_frame(16'hC000);
        drain();
        check("s3_errs", 32'(err_seen), 32'd0);
        check("s3_pixels", 32'(pix_seen), 32'd12);
        check("s3_first", 32'(first_pix), 32'hC000);

        // Short row
        clear_seen();
        tq.push_back(FS); tq.push_back(RS);
        for (int i = 0; i < 3; i++) tq.push_back({1'b0, 16'h0D00 + 16'(i)});
        tq.push_back(RS);
        add_frame(16'hD000);
        drain();
        check("s4_errs", 32'(err_seen), 32'd1);
        check("s4_errcnt", 32'(error_count), 32'd1);
        check("s4_pixels", 32'(pix_seen), 32'd15);
        check("s4_frames", 32'(done_seen), 32'd1);

        // Frame start after 5 pixels resynchronises immediately
        ready_mode = 1; clear_seen();
        tq.push_back(FS); tq.push_back(RS);
        for (int i = 0; i < 4; i++) tq.push_back({1'b0, 16'h0E00 + 16'(i)});
        tq.push_back(RS); tq.push_back({1'b0, 16'h0E04}); tq.push_back(FS);
        for (int r = 0; r < H; r++) begin
            tq.push_back(RS);
            for (int c = 0; c < W; c++) tq.push_back({1'b0, 16'hE000 + 16'(r * W + c)});
        end
        tq.push_back(FE);
        drain();
        check("s5_errcnt", 32'(error_count), 32'd2);
        check("s5_sof", 32'(sof_seen), 32'd2);
        check("s5_frames", 32'(done_seen), 32'd1);
        check("s5_pixels", 32'(pix_seen), 32'd17);

        // Missing frame end, then unknown marker inside a row
        ready_mode = 0; clear_seen();
        add_frame(16'h7000);
        void'(tq.pop_back());
        tq.push_back(RS);
        tq.push_back(FS); tq.push_back(RS);
        tq.push_back({1'b0, 16'h7100}); tq.push_back({1'b0, 16'h7101});
        tq.push_back(17'h10005);
        drain();
        check("s6_errcnt", 32'(error_count), 32'd4);
        check("s6_frames", 32'(done_seen), 32'd0);
        check("s6_pixels", 32'(pix_seen), 32'd14);

        // Reset mid-frame while the skid holds stalled pixels
        ready_mode = 2; clear_seen();
        tq.push_back(FS); tq.push_back(RS);
        for (int i = 0; i < 4; i++) tq.push_back({1'b0, 16'h0F00 + 16'(i)});
        tq.push_back(RS); tq.push_back({1'b0, 16'h0F04}); tq.push_back({1'b0, 16'h0F05});
        repeat (12) @(posedge clk);
        #1;
        check("s7_stalled", 32'(pix_valid), 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        m_pos = -1; m_cnt = 0; exp_q.delete();
        nxt_done = 1'b0; nxt_err = 1'b0; exp_done = 1'b0; exp_err = 1'b0; exp_cnt = 0;
        #1;
        check("s7_rst_valid", 32'(pix_valid), 32'd0);
        check("s7_rst_marks", 32'({pix_sof, pix_eol, pix_eof}), 32'd0);
        check("s7_rst_data", 32'(pix_data), 32'd0);
        check("s7_rst_count", 32'(error_count), 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        ready_mode = 0;
        tq.push_back({1'b0, 16'h0F06}); tq.push_back({1'b0, 16'h0F07});
        tq.push_back(RS);
        for (int i = 0; i < 4; i++) tq.push_back({1'b0, 16'h0F08 + 16'(i)});
        tq.push_back(FE);
        add_frame(16'hF000);
        drain();
        check("s7_errs", 32'(err_seen), 32'd0);
        check("s7_frames", 32'(done_seen), 32'd1);
        check("s7_pixels", 32'(pix_seen), 32'd12);
        check("s7_first", 32'(first_pix), 32'hF000);

        // Error counter saturation: 260 frame starts give 259 violations
        clear_seen();
        for (int i = 0; i < 260; i++) tq.push_back(FS);
        drain();
        check("s8_errs", 32'(err_seen), 32'd259);
        check("s8_errcnt", 32'(error_count), 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
